// File: rtl/boot_seq.sv
// Program-load and run sequencer: streams host words into CPU memory, then starts and watches the CPU.
// Optional build macro BOOT_SEQ_CLEAR_EN zeroes the whole memory before each load.
module boot_seq #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_req,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    input  logic          halt,
    output logic          memwe,
    output logic [AW-1:0] memaddr,
    output logic [DW-1:0] memin,
    output logic          start,
    output logic          busy,
    output logic          done,
    output logic          err_overflow,
    output logic [AW:0]   word_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
`ifdef BOOT_SEQ_CLEAR_EN
        CLEAR  = 3'd1,
`endif
        LOAD   = 3'd2,
        ARM    = 3'd3,
        RUN    = 3'd4,
        HALTED = 3'd5
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   WC_MAX    = (AW + 1)'(DEPTH);

`ifdef BOOT_SEQ_CLEAR_EN
    localparam state_t LOAD_ENTRY = CLEAR;
`else
    localparam state_t LOAD_ENTRY = LOAD;
`endif

    state_t        state, state_nxt;
    logic [AW-1:0] addr, addr_nxt;
    logic          memwe_nxt;
    logic [AW-1:0] memaddr_nxt;
    logic [DW-1:0] memin_nxt;
    logic [AW:0]   wc_nxt;
    logic          err_nxt;
    logic          load_start;
    logic          xfer;

    // Decoded from the state register only so the host handshake has no combinational input path.
    assign in_ready = (state == LOAD);
    assign xfer     = in_valid & in_ready;

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        memwe_nxt   = 1'b0;
        memaddr_nxt = memaddr;
        memin_nxt   = memin;
        wc_nxt      = word_count;
        err_nxt     = err_overflow;
        load_start  = 1'b0;

        case (state)
            IDLE, HALTED: begin
                if (load_req) load_start = 1'b1;
            end
`ifdef BOOT_SEQ_CLEAR_EN
            CLEAR: begin
                memwe_nxt   = 1'b1;
                memaddr_nxt = addr;
                memin_nxt   = '0;
                if (addr == LAST_ADDR) begin
                    state_nxt = LOAD;
                    addr_nxt  = '0;
                end else begin
                    addr_nxt = addr + 1'b1;
                end
            end
`endif
            LOAD: begin
                if (xfer) begin
                    memwe_nxt   = 1'b1;
                    memaddr_nxt = addr;
                    memin_nxt   = in_data;
                    if (word_count != WC_MAX) wc_nxt = word_count + 1'b1;
                    if (in_last) begin
                        state_nxt = ARM;
                    end else if (addr == LAST_ADDR) begin
                        // Overflow is caught before the address would wrap; no start is issued.
                        err_nxt   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        addr_nxt = addr + 1'b1;
                    end
                end
            end
            ARM: state_nxt = RUN;
            RUN: begin
                if (load_req)  load_start = 1'b1;
                else if (halt) state_nxt  = HALTED;
            end
            default: state_nxt = IDLE;
        endcase

        if (load_start) begin
            state_nxt = LOAD_ENTRY;
            addr_nxt  = '0;
            wc_nxt    = '0;
            err_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            addr         <= '0;
            memwe        <= 1'b0;
            memaddr      <= '0;
            memin        <= '0;
            word_count   <= '0;
            err_overflow <= 1'b0;
            start        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            addr         <= addr_nxt;
            memwe        <= memwe_nxt;
            memaddr      <= memaddr_nxt;
            memin        <= memin_nxt;
            word_count   <= wc_nxt;
            err_overflow <= err_nxt;
            start        <= (state_nxt == RUN);
            busy         <= (state_nxt != IDLE) && (state_nxt != HALTED);
            done         <= (state_nxt == HALTED);
        end
    end

endmodule

// File: tb/tb_boot_seq.sv
// Directed bench for boot_seq: memory writes checked against a scoreboard queue, control outputs checked per step.
module tb_boot_seq;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_req;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          in_ready;
    logic          halt;
    logic          memwe;
    logic [AW-1:0] memaddr;
    logic [DW-1:0] memin;
    logic          start;
    logic          busy;
    logic          done;
    logic          err_overflow;
    logic [AW:0]   word_count;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW+DW-1:0] sb[$];

    boot_seq #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
        .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .halt(halt),
        .memwe(memwe), .memaddr(memaddr), .memin(memin), .start(start),
        .busy(busy), .done(done), .err_overflow(err_overflow), .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_req = 1'b1;
`ifdef BOOT_SEQ_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) sb.push_back({AW'(i), {DW{1'b0}}});
`endif
        step();
        load_req = 1'b0;
`ifdef BOOT_SEQ_CLEAR_EN
        repeat (DEPTH) step();
`endif
    endtask

    task automatic send(input logic [DW-1:0] d, input logic last, input int a);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        sb.push_back({AW'(a), d});
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start"}, start, 1'b0);
        check({tag, "_memwe"}, memwe, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err"}, err_overflow, 1'b0);
        check({tag, "_memaddr"}, memaddr, 0);
        check({tag, "_memin"}, memin, 0);
        check({tag, "_wc"}, word_count, 0);
    endtask

    initial begin
        logic [DW-1:0] w4 [4];
        w4[0] = 32'h11; w4[1] = 32'h22; w4[2] = 32'h33; w4[3] = 32'h44;

        rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; halt = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (memwe === 1'b1) begin
                    if (sb.size() == 0) begin
                        check("write_expected", {memaddr, memin}, 64'hDEAD_BEEF);
                    end else begin
                        logic [AW+DW-1:0] e;
                        e = sb.pop_front();
                        check("wr_addr", memaddr, e[AW+DW-1:DW]);
                        check("wr_data", memin, e[DW-1:0]);
                    end
                end
            end
        join_none

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        step();
        rst = 1'b0;
        step();

        // Back-to-back 4-word program.
        start_load();
        @(negedge clk);
        check("load_in_ready", in_ready, 1'b1);
        check("load_busy", busy, 1'b1);
        step();
        for (int i = 0; i < 4; i++) send(w4[i], i == 3, i);
        @(negedge clk);
        check("arm_start", start, 1'b0);
        check("arm_in_ready", in_ready, 1'b0);
        step();
        @(negedge clk);
        check("run_start", start, 1'b1);
        check("run_busy", busy, 1'b1);
        check("run_wc4", word_count, 4);
        step();

        // halt ends the run.
        halt = 1'b1;
        step();
        halt = 1'b0;
        @(negedge clk);
        check("halt_start", start, 1'b0);
        check("halt_done", done, 1'b1);
        check("halt_busy", busy, 1'b0);
        check("halt_wc", word_count, 4);
        step();

        // Same program with two-cycle valid gaps, reloaded from HALTED.
        start_load();
        for (int i = 0; i < 4; i++) begin
            send(w4[i], i == 3, i);
            if (i != 3) begin
                repeat (2) begin
                    @(negedge clk);
                    check("gap_in_ready", in_ready, 1'b1);
                    step();
                end
            end
        end
        step();
        @(negedge clk);
        check("gap_run_start", start, 1'b1);
        check("gap_wc", word_count, 4);
        check("gap_done", done, 1'b0);
        step();

        // load_req wins over halt in RUN.
        load_req = 1'b1;
        halt     = 1'b1;
        step();
        load_req = 1'b0;
        halt     = 1'b0;
        @(negedge clk);
        check("abort_start", start, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_busy", busy, 1'b1);
        check("abort_wc", word_count, 0);
`ifdef BOOT_SEQ_CLEAR_EN
        for (int i = 0; i < DEPTH; i++) sb.push_back({AW'(i), {DW{1'b0}}});
        repeat (DEPTH) step();
`else
        check("abort_in_ready", in_ready, 1'b1);
`endif

        // Full 32-word program with in_last on the final word.
        for (int i = 0; i < DEPTH; i++) send(32'hA500_0000 + i, i == DEPTH - 1, i);
        @(negedge clk);
        check("full_err", err_overflow, 1'b0);
        step();
        @(negedge clk);
        check("full_start", start, 1'b1);
        check("full_wc", word_count, DEPTH);
        step();

        // 32 words without in_last overflow.
        start_load();
        for (int i = 0; i < DEPTH; i++) send(32'h5A00_0000 + i, 1'b0, i);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        check("ovf_err", err_overflow, 1'b1);
        check("ovf_in_ready", in_ready, 1'b0);
        check("ovf_start", start, 1'b0);
        check("ovf_busy", busy, 1'b0);
        check("ovf_wc", word_count, DEPTH);
        repeat (3) step();
        @(negedge clk);
        check("ovf_hold_err", err_overflow, 1'b1);
        check("ovf_hold_start", start, 1'b0);
        check("ovf_hold_in_ready", in_ready, 1'b0);
        in_valid = 1'b0;
        step();

        // Reset in the middle of a load, then reload from address 0.
        start_load();
        for (int i = 0; i < 3; i++) send(32'hC0 + i, 1'b0, i);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_idle_outputs("midrst");
        #2;
        rst = 1'b0;
        step();
        start_load();
        send(32'hAB, 1'b1, 0);
        step();
        @(negedge clk);
        check("reload_start", start, 1'b1);
        check("reload_wc", word_count, 1);

        repeat (3) step();
        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/boot_seq.md
# boot_seq

Program-load and run sequencer for the multicycle CPU. Accepts a program as a valid/ready word stream from the host, writes it into the CPU's 32-word memory through the datapath's external load port (`memwe`/`memaddr`/`memin`), then drives `start` to the control unit and tracks completion via `halt`. It sits between the host interface and the CPU top level, and is the only driver of the CPU's load port and `start`.

## Interface
- `DW`, 32, memory word width.
- `AW`, 5, memory address width.
- `DEPTH`, 32, number of memory words; must equal 2**AW.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `load_req`  in  1  level; start a new load (sampled in IDLE, RUN, HALTED).
- `in_valid`  in  1  host word valid.
- `in_data`  in  DW  host word.
- `in_last`  in  1  marks final word of the program.
- `in_ready`  out  1  sequencer accepts a word this cycle.
- `halt`  in  1  CPU has finished (level, from control/decoder).
- `memwe`  out  1  memory write enable to datapath.
- `memaddr`  out  AW  memory write address.
- `memin`  out  DW  memory write data.
- `start`  out  1  run enable to control unit.
- `busy`  out  1  high in any state except IDLE and HALTED.
- `done`  out  1  high in HALTED.
- `err_overflow`  out  1  sticky: program longer than DEPTH words.
- `word_count`  out  AW+1  words written in the last/current load (0..DEPTH).

## Operation
- States: IDLE, CLEAR (macro only), LOAD, ARM, RUN, HALTED.
- IDLE: `in_ready`=0. `load_req`=1 → CLEAR (macro) or LOAD; clears `word_count`, `err_overflow`, address counter.
- CLEAR: writes 0 to addresses 0..DEPTH-1, one per cycle; `in_ready`=0; after address DEPTH-1 → LOAD.
- LOAD: `in_ready`=1. Transfer = `in_valid & in_ready`. Each transfer writes `in_data` to current address, address and `word_count` increment.
  - Transfer with `in_last`=1 → ARM.
  - Transfer at address DEPTH-1 with `in_last`=0 → set `err_overflow`, → IDLE (no start). Further host words are not accepted.
  - `in_valid`=0: hold, no write.
- ARM: one cycle, `in_ready`=0, lets final write settle; → RUN.
- RUN: `start`=1 held every cycle. `halt`=1 → HALTED. `load_req`=1 (priority over `halt`) → abort: `start` drops, → CLEAR/LOAD with counters cleared.
- HALTED: `start`=0, `done`=1, counters and `word_count` held. `load_req`=1 → new load as from IDLE.
- `halt` ignored outside RUN. `load_req` ignored in CLEAR/LOAD/ARM.

## Timing
- All outputs registered except `in_ready` (decoded from state register only, no input path).
- Write latency: transfer in cycle N → `memwe`=1 with that address/data in cycle N+1; `memwe`=0 otherwise.
- Throughput: one word per cycle; program of K words reaches RUN (`start`=1) at cycle N_last+2.
- CLEAR takes exactly DEPTH cycles.
- `halt` in cycle N → `start`=0, `done`=1 in cycle N+1.
- Reset (any time, incl. mid-load or RUN): state IDLE; `start`, `memwe`, `in_ready`, `busy`, `done`, `err_overflow`=0; `memaddr`, `memin`, `word_count`=0. Partial memory contents are not restored.
- Address counter is AW bits and never wraps: overflow is detected before increment past DEPTH-1; `word_count` saturates at DEPTH.

## Configuration
- `BOOT_SEQ_CLEAR_EN` defined: every load passes through CLEAR, zeroing all DEPTH words before the first host word is accepted; unused memory reads as 0.
- Not defined: CLEAR state absent; load goes IDLE → LOAD directly; words above the program retain prior contents.

## Test plan
- Reset then `load_req`, stream 4 words 0x11,0x22,0x33,0x44 back-to-back with `in_last` on 4th → `memwe` at addr 0..3 with those values on consecutive cycles, `word_count`=4, `start`=1 two cycles after last transfer.
- Same stream with `in_valid` gaps of 2 cycles between words → no `memwe` during gaps, identical final writes, `in_ready` stays 1.
- 32 words, last has `in_last` → no error, `word_count`=32, RUN; 32 words without `in_last` → `err_overflow`=1, IDLE, `start` never asserted, `in_ready`=0.
- In RUN assert `halt` one cycle → next cycle `start`=0, `done`=1, `busy`=0; `load_req` and `halt` together in RUN → abort to load, `done`=0.
- Assert `rst` mid-LOAD after 3 words → all outputs 0 immediately, IDLE; subsequent load restarts at address 0.
- With `BOOT_SEQ_CLEAR_EN`: `load_req` → 32 cycles of `memwe` with `memin`=0 at addr 0..31, `in_ready`=0 throughout, then LOAD with `in_ready`=1.
